// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads the 1-cycle-latency instruction ROM and feeds a 2-deep FIFO
// to the decoder. Define FETCH_HALT_EN to stop fetching after the func/done word (9'h1FF).
module instr_fetch #(
  parameter int              PC_W     = 32'd10,
  parameter int              INSTR_W  = 32'd9,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               rom_rd_en,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir_data,
  output logic [PC_W-1:0]    ir_pc,
  input  logic               ir_ready,
  output logic               halted
);

  localparam int ENT_W = PC_W + INSTR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic               inflight_r;
  logic [PC_W-1:0]    inflight_pc_r;
  logic [ENT_W-1:0]   buf0_r, buf1_r, buf0_s, buf1_s;
  logic [1:0]         count_r, count_s;
  logic [2:0]         occ_s;
  logic               flush_s, pop_s, push_s, issue_s, stop_s;

`ifdef FETCH_HALT_EN
  logic stop_r;

  function automatic logic is_done(input logic [INSTR_W-1:0] w);
    return (w[8:4] == 5'b11111) && (w[3:0] == 4'hF);
  endfunction

  // Latch the stop request once the done word is captured; a redirect cancels it.
  always_ff @(posedge clk) begin
    if (!reset_n)
      stop_r <= 1'b0;
    else if (flush_s)
      stop_r <= 1'b0;
    else if (push_s && is_done(rom_data))
      stop_r <= 1'b1;
    else
      stop_r <= stop_r;
  end

  assign stop_s = stop_r;
  assign halted = (state_r == HALT);
`else
  assign stop_s = 1'b0;
  assign halted = 1'b0;
`endif

  // Handshake and issue decisions; occupancy counts this cycle's pop so fetch runs back-to-back.
  always_comb begin
    flush_s = (state_r == RUN) && redirect_valid;
    pop_s   = (count_r != 2'd0) && ir_ready;
    push_s  = (state_r == RUN) && inflight_r && !redirect_valid && !stop_s;
    occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s = (state_r == RUN) && !redirect_valid && !stop_s && (occ_s < 3'd2);
  end

  // Next FIFO contents: head in buf0, shift on pop, returned word lands behind the survivors.
  always_comb begin
    buf0_s  = buf0_r;
    buf1_s  = buf1_r;
    count_s = count_r;
    if (flush_s) begin
      count_s = 2'd0;
    end else begin
      if (pop_s) begin
        buf0_s  = buf1_r;
        count_s = count_r - 2'd1;
      end else begin
        count_s = count_r;
      end
      if (push_s) begin
        if (count_s == 2'd0)
          buf0_s = {inflight_pc_r, rom_data};
        else
          buf1_s = {inflight_pc_r, rom_data};
        count_s = count_s + 2'd1;
      end else begin
        count_s = count_s;
      end
    end
  end

  // Next state and PC.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    case (state_r)
      IDLE: begin
        if (redirect_valid)
          pc_s = redirect_pc;
        else if (start)
          state_s = RUN;
        else
          state_s = IDLE;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_s = redirect_pc;
        end else begin
          if (issue_s)
            pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
          else
            pc_s = pc_r;
          if (stop_s && (count_s == 2'd0))
            state_s = HALT;
          else
            state_s = RUN;
        end
      end
      HALT:    state_s = HALT;
      default: state_s = IDLE;
    endcase
  end

  // State, PC, in-flight tracking and FIFO storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {PC_W{1'b0}};
      buf0_r        <= {ENT_W{1'b0}};
      buf1_r        <= {ENT_W{1'b0}};
      count_r       <= 2'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      inflight_r <= issue_s;
      if (issue_s)
        inflight_pc_r <= pc_r;
      else
        inflight_pc_r <= inflight_pc_r;
      buf0_r  <= buf0_s;
      buf1_r  <= buf1_s;
      count_r <= count_s;
    end
  end

  assign rom_rd_en = issue_s;
  assign rom_addr  = issue_s ? pc_r : {PC_W{1'b0}};
  assign ir_valid  = (count_r != 2'd0);
  assign ir_data   = buf0_r[INSTR_W-1:0];
  assign ir_pc     = buf0_r[ENT_W-1:INSTR_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases plus random ready/redirect traffic, checked against a
// program-order model (expected issue/delivery addresses, ROM table, occupancy bound).
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       reset_n, start, rom_rd_en, redirect_valid, ir_valid, ir_ready, halted;
  logic [9:0] rom_addr, redirect_pc, ir_pc;
  logic [8:0] rom_data, ir_data;

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_data(ir_data), .ir_pc(ir_pc),
    .ir_ready(ir_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [0:1023];

  // ROM: one-cycle read latency, garbage on the bus when not read
  always @(posedge clk) rom_data <= rom_rd_en ? rom[rom_addr] : 9'($urandom);

  int checks = 0;
  int errors = 0;

  // model of the fetch stream in program order
  bit         m_run, m_stopped, prev_hold;
  logic [9:0] exp_issue, exp_deliv, prev_pc;
  logic [8:0] prev_data;
  int         outst, max_addr, n_deliv;
  logic [9:0] deliv_q [$];
  logic       s_rd_en, s_valid, s_halted;
  logic [9:0] s_addr, s_pc;
  logic [8:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sample 1 time unit after the falling edge (inputs already driven), update model, go to next falling edge
  task automatic tick();
    bit stop_now;
    stop_now = 1'b0;
    #1;
    s_rd_en = rom_rd_en; s_addr = rom_addr; s_valid = ir_valid;
    s_pc = ir_pc; s_data = ir_data; s_halted = halted;
    if (!reset_n) begin
      m_run = 1'b0; m_stopped = 1'b0; prev_hold = 1'b0;
      exp_issue = 10'd0; exp_deliv = 10'd0; outst = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(ir_valid), 32'd1);
        chk("hold_pc", 32'(ir_pc), 32'(prev_pc));
        chk("hold_data", 32'(ir_data), 32'(prev_data));
      end
      if (!m_run || m_stopped) chk("no_read_idle_halt", 32'(rom_rd_en), 32'd0);
      if (m_run && !m_stopped && redirect_valid) chk("no_read_on_redirect", 32'(rom_rd_en), 32'd0);
      if (m_stopped) chk("halt_no_valid", 32'(ir_valid), 32'd0);
      chk("halted", 32'(halted), 32'(m_stopped));
      if (rom_rd_en) begin
        chk("issue_addr", 32'(rom_addr), 32'(exp_issue));
        if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
        exp_issue = exp_issue + 10'd1;
        outst++;
      end
      if (ir_valid && ir_ready) begin
        chk("deliv_pc", 32'(ir_pc), 32'(exp_deliv));
        chk("deliv_data", 32'(ir_data), 32'(rom[exp_deliv]));
        deliv_q.push_back(ir_pc);
        n_deliv++;
`ifdef FETCH_HALT_EN
        if (rom[exp_deliv] == 9'h1FF) stop_now = 1'b1;
`endif
        exp_deliv = exp_deliv + 10'd1;
        outst--;
      end
      if (redirect_valid && !m_stopped) begin
        exp_issue = redirect_pc;
        exp_deliv = redirect_pc;
        outst = 0;
      end
      chk("occupancy", 32'(outst <= 2), 32'd1);
      if (start && !m_run && !redirect_valid) m_run = 1'b1;
      prev_hold = ir_valid && !ir_ready && !redirect_valid && m_run && !m_stopped;
      prev_pc = ir_pc; prev_data = ir_data;
      if (stop_now) m_stopped = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(s_rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(s_addr), 32'd0);
    chk({tag, "_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_data"}, 32'(s_data), 32'd0);
    chk({tag, "_pc"}, 32'(s_pc), 32'd0);
    chk({tag, "_halted"}, 32'(s_halted), 32'd0);
  endtask

  initial begin
    logic [8:0] v;
    logic [9:0] wrap_exp [4];
    for (int i = 0; i < 1024; i++) begin
      if (i < 64) begin
        rom[i] = 9'(i);
      end else begin
        do v = 9'($urandom); while (v == 9'h1FF);
        rom[i] = v;
      end
    end
    reset_n = 1'b0; start = 1'b0; ir_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 10'd0;
    max_addr = 0; n_deliv = 0;
    @(negedge clk);

    // reset state
    tick(); tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk("idle_no_read", 32'(s_rd_en), 32'd0);

    // start, back-to-back fetch from 0
    start = 1'b1; ir_ready = 1'b1;
    tick();
    chk("start_cycle_rd_en", 32'(s_rd_en), 32'd0);
    start = 1'b0;
    tick();
    chk("first_rd_en", 32'(s_rd_en), 32'd1);
    chk("first_addr", 32'(s_addr), 32'd0);
    chk("first_valid_n0", 32'(s_valid), 32'd0);
    tick();
    chk("second_addr", 32'(s_addr), 32'd1);
    chk("first_valid_n1", 32'(s_valid), 32'd0);
    tick();
    chk("first_ir_valid", 32'(s_valid), 32'd1);
    chk("first_ir_pc", 32'(s_pc), 32'd0);
    chk("first_ir_data", 32'(s_data), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("steady_rd_en", 32'(s_rd_en), 32'd1);
      chk("steady_pc_eq_data", 32'(s_pc[8:0]), 32'(s_data));
    end

    // decoder stall
    ir_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_read", 32'(s_rd_en), 32'd0);
      chk("stall_valid", 32'(s_valid), 32'd1);
    end
    chk("stall_outstanding", 32'(outst), 32'd2);
    ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();

    // redirect with two words buffered
    ir_ready = 1'b0;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 10'h100;
    tick();
    chk("redir_rd_en", 32'(s_rd_en), 32'd0);
    redirect_valid = 1'b0; ir_ready = 1'b1;
    tick();
    chk("redir_next_addr", 32'(s_addr), 32'h100);
    chk("redir_next_rd_en", 32'(s_rd_en), 32'd1);
    chk("redir_flushed", 32'(s_valid), 32'd0);
    tick();
    tick();
    chk("redir_ir_valid", 32'(s_valid), 32'd1);
    chk("redir_ir_pc", 32'(s_pc), 32'h100);

    // PC wrap
    redirect_valid = 1'b1; redirect_pc = 10'h3FE;
    tick();
    redirect_valid = 1'b0;
    deliv_q.delete();
    for (int i = 0; i < 8; i++) tick();
    wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
    chk("wrap_count", 32'(deliv_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      if (i < deliv_q.size()) chk("wrap_pc", 32'(deliv_q[i]), 32'(wrap_exp[i]));

    // random ready and redirects
    for (int i = 0; i < 400; i++) begin
      ir_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = 10'($urandom);
      tick();
    end
    redirect_valid = 1'b0;

    // reset in the middle of a run
    ir_ready = 1'b1;
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk_reset_outputs("midreset");
    tick();
    chk("midreset_stale_word", 32'(s_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    deliv_q.delete();
    for (int i = 0; i < 6; i++) tick();
    chk("restart_count", 32'(deliv_q.size() >= 1), 32'd1);
    if (deliv_q.size() >= 1) chk("restart_pc", 32'(deliv_q[0]), 32'd0);

    // func/done word at address 3
    reset_n = 1'b0;
    rom[3] = 9'h1FF;
    tick();
    reset_n = 1'b1;
    max_addr = 0; n_deliv = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
`ifdef FETCH_HALT_EN
    chk("halt_halted", 32'(s_halted), 32'd1);
    chk("halt_delivered", 32'(n_deliv), 32'd4);
    chk("halt_max_addr", 32'(max_addr), 32'd4);
    redirect_valid = 1'b1; redirect_pc = 10'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("halt_redir_rd_en", 32'(s_rd_en), 32'd0);
    chk("halt_redir_valid", 32'(s_valid), 32'd0);
    chk("halt_redir_halted", 32'(s_halted), 32'd1);
`else
    chk("nohalt_continues", 32'(n_deliv > 4), 32'd1);
    chk("nohalt_halted", 32'(s_halted), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
